stopwatch_ctrl: RTL and testbench

Stopwatch controller that sequences the 10 ms base-tick timer and turns its output into a BCD time count. It takes debounced single-cycle button pulses (start/stop, lap, clear), runs a four-state FSM, drives the timer's enable and active-low reset, and counts rising edges of the timer's 100 Hz base tick into MM:SS.CC digits. It has a lap-freeze display path. It sits between the button debouncers and the seven-segment display driver.

---
 rtl/stopwatch_pkg.sv | 34 +++
 rtl/stopwatch_if.sv | 30 +++
 rtl/bcd_digit_counter.sv | 25 ++
 rtl/stopwatch_ctrl.sv | 152 +++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch controller slice.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    LAP   = 2'd3
  } sw_state_e;

  localparam int unsigned BCD_W   = 4;
  localparam int unsigned CS_MAX  = 99;
  localparam int unsigned SEC_MAX = 59;

  typedef logic [BCD_W-1:0] bcd_t;

  typedef struct packed {
    bcd_t min_t;
    bcd_t min_o;
    bcd_t sec_t;
    bcd_t sec_o;
    bcd_t cs_t;
    bcd_t cs_o;
  } time_t;

  function automatic bcd_t tens_digit(input int unsigned v);
    return bcd_t'(v / 10);
  endfunction

  function automatic bcd_t ones_digit(input int unsigned v);
    return bcd_t'(v % 10);
  endfunction

endpackage

// File: rtl/stopwatch_if.sv
// Button/tick inputs and timer/display outputs of the stopwatch controller.
interface stopwatch_if import stopwatch_pkg::*; ();
  logic i_start_stop;
  logic i_lap;
  logic i_clear;
  logic i_basetick;
  logic o_timerenb;
  logic o_timer_reset_n;
  logic o_running;
  logic o_lap_active;
  logic o_overflow;
  bcd_t o_min_t;
  bcd_t o_min_o;
  bcd_t o_sec_t;
  bcd_t o_sec_o;
  bcd_t o_cs_t;
  bcd_t o_cs_o;

  modport master (
    output i_start_stop, i_lap, i_clear, i_basetick,
    input  o_timerenb, o_timer_reset_n, o_running, o_lap_active, o_overflow,
    input  o_min_t, o_min_o, o_sec_t, o_sec_o, o_cs_t, o_cs_o
  );

  modport slave (
    input  i_start_stop, i_lap, i_clear, i_basetick,
    output o_timerenb, o_timer_reset_n, o_running, o_lap_active, o_overflow,
    output o_min_t, o_min_o, o_sec_t, o_sec_o, o_cs_t, o_cs_o
  );
endinterface

// File: rtl/bcd_digit_counter.sv
// One BCD digit counting 0..LIMIT; carry is combinational so digits chain in one cycle.
module bcd_digit_counter import stopwatch_pkg::*; #(
  parameter int unsigned LIMIT = 9
) (
  input  logic i_sclk,
  input  logic i_reset,
  input  logic inc,
  input  logic clr,
  output bcd_t value,
  output logic carry
);

  localparam bcd_t LIM = bcd_t'(LIMIT);

  always_ff @(posedge i_sclk) begin
    if (i_reset || clr) begin
      value <= '0;
    end else if (inc) begin
      value <= (value == LIM) ? '0 : value + bcd_t'(1);
    end
  end

  assign carry = inc && (value == LIM);

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch FSM, timer control and MM:SS.CC BCD count with lap freeze.
// Define STOPWATCH_WRAP_EN to wrap at MAX_MIN:59.99 instead of saturating.
module stopwatch_ctrl import stopwatch_pkg::*; #(
  parameter int unsigned MAX_MIN = 99
) (
  input logic        i_sclk,
  input logic        i_reset,
  stopwatch_if.slave sw
);

  localparam logic [1:0] ST_IDLE  = 2'(IDLE);
  localparam logic [1:0] ST_RUN   = 2'(RUN);
  localparam logic [1:0] ST_PAUSE = 2'(PAUSE);
  localparam logic [1:0] ST_LAP   = 2'(LAP);

  localparam time_t MAX_TIME = {tens_digit(MAX_MIN), ones_digit(MAX_MIN),
                                tens_digit(SEC_MAX), ones_digit(SEC_MAX),
                                tens_digit(CS_MAX),  ones_digit(CS_MAX)};

  logic [1:0] state_q, state_d;
  logic       latch_lap, do_clear;
  logic       basetick_q, tick, counting, tick_en, at_max;
  logic       ss_w, lap_w, clr_w;
  logic       inc_cs, clr_cnt, ovf_set, ovf_q;
  logic       c_cs_o, c_cs_t, c_sec_o, c_sec_t, c_min_o, c_min_t;
  bcd_t       min_t, min_o, sec_t, sec_o, cs_t, cs_o;
  time_t      live, lap_q, disp;

  // Only the highest-priority pulse acts: clear > start_stop > lap
  assign clr_w = sw.i_clear;
  assign ss_w  = sw.i_start_stop & ~sw.i_clear;
  assign lap_w = sw.i_lap & ~sw.i_start_stop & ~sw.i_clear;

  always_ff @(posedge i_sclk) begin
    if (i_reset) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    latch_lap = 1'b0;
    do_clear  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ss_w) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (ss_w) begin
          state_d = ST_PAUSE;
        end else if (lap_w) begin
          state_d   = ST_LAP;
          latch_lap = 1'b1;
        end
      end
      ST_LAP: begin
        if (ss_w)       state_d = ST_PAUSE;
        else if (lap_w) state_d = ST_RUN;
      end
      ST_PAUSE: begin
        if (clr_w) begin
          state_d  = ST_IDLE;
          do_clear = 1'b1;
        end else if (ss_w) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Rising edge of the 100 Hz base tick is one centisecond
  always_ff @(posedge i_sclk) begin
    if (i_reset) basetick_q <= 1'b0;
    else         basetick_q <= sw.i_basetick;
  end

  assign tick     = sw.i_basetick & ~basetick_q;
  assign counting = (state_q == ST_RUN) || (state_q == ST_LAP);
  assign tick_en  = tick & counting;
  assign live     = {min_t, min_o, sec_t, sec_o, cs_t, cs_o};
  assign at_max   = (live == MAX_TIME);
  assign inc_cs   = tick_en & ~at_max;

`ifdef STOPWATCH_WRAP_EN
  assign ovf_set = tick_en & at_max;
  // Minutes-tens rollover cannot occur while at_max gates the chain; kept as a safe wrap
  assign clr_cnt = do_clear | ovf_set | c_min_t;

  always_ff @(posedge i_sclk) begin
    if (i_reset) ovf_q <= 1'b0;
    else         ovf_q <= ovf_set;
  end
`else
  assign ovf_set = tick_en & at_max;
  assign clr_cnt = do_clear | c_min_t;

  always_ff @(posedge i_sclk) begin
    if (i_reset || do_clear) ovf_q <= 1'b0;
    else if (ovf_set)        ovf_q <= 1'b1;
  end
`endif

  bcd_digit_counter #(.LIMIT(CS_MAX % 10)) u_cs_o (
    .i_sclk(i_sclk), .i_reset(i_reset), .inc(inc_cs),  .clr(clr_cnt), .value(cs_o),  .carry(c_cs_o));
  bcd_digit_counter #(.LIMIT(CS_MAX / 10)) u_cs_t (
    .i_sclk(i_sclk), .i_reset(i_reset), .inc(c_cs_o),  .clr(clr_cnt), .value(cs_t),  .carry(c_cs_t));
  bcd_digit_counter #(.LIMIT(9)) u_sec_o (
    .i_sclk(i_sclk), .i_reset(i_reset), .inc(c_cs_t),  .clr(clr_cnt), .value(sec_o), .carry(c_sec_o));
  bcd_digit_counter #(.LIMIT(SEC_MAX / 10)) u_sec_t (
    .i_sclk(i_sclk), .i_reset(i_reset), .inc(c_sec_o), .clr(clr_cnt), .value(sec_t), .carry(c_sec_t));
  bcd_digit_counter #(.LIMIT(9)) u_min_o (
    .i_sclk(i_sclk), .i_reset(i_reset), .inc(c_sec_t), .clr(clr_cnt), .value(min_o), .carry(c_min_o));
  bcd_digit_counter #(.LIMIT(9)) u_min_t (
    .i_sclk(i_sclk), .i_reset(i_reset), .inc(c_min_o), .clr(clr_cnt), .value(min_t), .carry(c_min_t));

  // Lap register captures the pre-increment count
  always_ff @(posedge i_sclk) begin
    if (i_reset)        lap_q <= '0;
    else if (latch_lap) lap_q <= live;
  end

  assign disp = (state_q == ST_LAP) ? lap_q : live;

  always_ff @(posedge i_sclk) begin
    if (i_reset) begin
      sw.o_timerenb      <= 1'b0;
      sw.o_timer_reset_n <= 1'b0;
      sw.o_running       <= 1'b0;
      sw.o_lap_active    <= 1'b0;
      sw.o_overflow      <= 1'b0;
      sw.o_min_t         <= '0;
      sw.o_min_o         <= '0;
      sw.o_sec_t         <= '0;
      sw.o_sec_o         <= '0;
      sw.o_cs_t          <= '0;
      sw.o_cs_o          <= '0;
    end else begin
      sw.o_timerenb      <= counting;
      sw.o_timer_reset_n <= (state_q != ST_IDLE);
      sw.o_running       <= counting;
      sw.o_lap_active    <= (state_q == ST_LAP);
      sw.o_overflow      <= ovf_q;
      sw.o_min_t         <= disp.min_t;
      sw.o_min_o         <= disp.min_o;
      sw.o_sec_t         <= disp.sec_t;
      sw.o_sec_o         <= disp.sec_o;
      sw.o_cs_t          <= disp.cs_t;
      sw.o_cs_o          <= disp.cs_o;
    end
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with MAX_MIN=1 so the overflow boundary is reachable quickly.
module tb_stopwatch_ctrl;

  logic i_sclk  = 1'b0;
  logic i_reset = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  stopwatch_if sw_if ();

  stopwatch_ctrl #(.MAX_MIN(1)) dut (
    .i_sclk (i_sclk),
    .i_reset(i_reset),
    .sw     (sw_if.slave)
  );

  always #5 i_sclk = ~i_sclk;

  wire [23:0] disp = {sw_if.o_min_t, sw_if.o_min_o, sw_if.o_sec_t,
                      sw_if.o_sec_o, sw_if.o_cs_t, sw_if.o_cs_o};

  task automatic step();
    @(posedge i_sclk);
    #1;
  endtask

  task automatic tick();
    sw_if.i_basetick = 1'b1;
    step();
    sw_if.i_basetick = 1'b0;
    step();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic press_ss();
    sw_if.i_start_stop = 1'b1;
    step();
    sw_if.i_start_stop = 1'b0;
  endtask

  task automatic press_lap();
    sw_if.i_lap = 1'b1;
    step();
    sw_if.i_lap = 1'b0;
  endtask

  task automatic press_clear();
    sw_if.i_clear = 1'b1;
    step();
    sw_if.i_clear = 1'b0;
  endtask

  task automatic test_reset();
    i_reset = 1'b1;
    repeat (3) step();
    n_checks++;
    if ({sw_if.o_timerenb, sw_if.o_timer_reset_n, sw_if.o_running,
         sw_if.o_lap_active, sw_if.o_overflow} !== 5'b00000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 00000", {sw_if.o_timerenb,
               sw_if.o_timer_reset_n, sw_if.o_running, sw_if.o_lap_active, sw_if.o_overflow});
    end
    n_checks++;
    if (disp !== 24'h000000) begin
      n_fail++;
      $display("FAIL reset_digits: got %h expected 000000", disp);
    end
    i_reset = 1'b0;
    step();
    tick();
    n_checks++;
    if (sw_if.o_timer_reset_n !== 1'b0 || disp !== 24'h000000) begin
      n_fail++;
      $display("FAIL idle_tick_ignored: got rstn=%b digits=%h expected rstn=0 digits=000000",
               sw_if.o_timer_reset_n, disp);
    end
  endtask

  task automatic test_start_count();
    press_ss();
    n_checks++;
    if (sw_if.o_timerenb !== 1'b0) begin
      n_fail++;
      $display("FAIL start_latency_early: got %b expected 0", sw_if.o_timerenb);
    end
    step();
    n_checks++;
    if ({sw_if.o_timerenb, sw_if.o_timer_reset_n, sw_if.o_running} !== 3'b111) begin
      n_fail++;
      $display("FAIL start_run_flags: got %b expected 111",
               {sw_if.o_timerenb, sw_if.o_timer_reset_n, sw_if.o_running});
    end
    ticks(250);
    n_checks++;
    if (disp !== 24'h000250) begin
      n_fail++;
      $display("FAIL count_250: got %h expected 000250", disp);
    end
  endtask

  task automatic test_carry();
    ticks(5749);
    n_checks++;
    if (disp !== 24'h005999) begin
      n_fail++;
      $display("FAIL count_5999: got %h expected 005999", disp);
    end
    tick();
    n_checks++;
    if (disp !== 24'h010000) begin
      n_fail++;
      $display("FAIL minute_carry: got %h expected 010000", disp);
    end
  endtask

  task automatic test_pause_clear();
    press_ss();
    step();
    n_checks++;
    if ({sw_if.o_timerenb, sw_if.o_timer_reset_n, sw_if.o_running} !== 3'b010) begin
      n_fail++;
      $display("FAIL pause_flags: got %b expected 010",
               {sw_if.o_timerenb, sw_if.o_timer_reset_n, sw_if.o_running});
    end
    tick();
    n_checks++;
    if (disp !== 24'h010000) begin
      n_fail++;
      $display("FAIL pause_tick_ignored: got %h expected 010000", disp);
    end
    sw_if.i_start_stop = 1'b1;
    sw_if.i_clear      = 1'b1;
    sw_if.i_lap        = 1'b1;
    step();
    sw_if.i_start_stop = 1'b0;
    sw_if.i_clear      = 1'b0;
    sw_if.i_lap        = 1'b0;
    step();
    n_checks++;
    if ({sw_if.o_timer_reset_n, sw_if.o_running, sw_if.o_lap_active} !== 3'b000 ||
        disp !== 24'h000000) begin
      n_fail++;
      $display("FAIL clear_priority: got flags=%b digits=%h expected flags=000 digits=000000",
               {sw_if.o_timer_reset_n, sw_if.o_running, sw_if.o_lap_active}, disp);
    end
  endtask

  task automatic test_lap();
    press_ss();
    step();
    ticks(300);
    press_lap();
    step();
    n_checks++;
    if (sw_if.o_lap_active !== 1'b1 || disp !== 24'h000300) begin
      n_fail++;
      $display("FAIL lap_latch: got lap=%b digits=%h expected lap=1 digits=000300",
               sw_if.o_lap_active, disp);
    end
    ticks(100);
    n_checks++;
    if (disp !== 24'h000300 || sw_if.o_running !== 1'b1) begin
      n_fail++;
      $display("FAIL lap_frozen: got run=%b digits=%h expected run=1 digits=000300",
               sw_if.o_running, disp);
    end
    press_lap();
    step();
    n_checks++;
    if (sw_if.o_lap_active !== 1'b0 || disp !== 24'h000400) begin
      n_fail++;
      $display("FAIL lap_release: got lap=%b digits=%h expected lap=0 digits=000400",
               sw_if.o_lap_active, disp);
    end
    press_clear();
    step();
    n_checks++;
    if (sw_if.o_running !== 1'b1 || disp !== 24'h000400) begin
      n_fail++;
      $display("FAIL run_clear_ignored: got run=%b digits=%h expected run=1 digits=000400",
               sw_if.o_running, disp);
    end
  endtask

  task automatic test_pause_with_tick();
    sw_if.i_start_stop = 1'b1;
    sw_if.i_basetick   = 1'b1;
    step();
    sw_if.i_start_stop = 1'b0;
    sw_if.i_basetick   = 1'b0;
    step();
    n_checks++;
    if (sw_if.o_running !== 1'b0 || disp !== 24'h000401) begin
      n_fail++;
      $display("FAIL pause_same_cycle_tick: got run=%b digits=%h expected run=0 digits=000401",
               sw_if.o_running, disp);
    end
    press_clear();
    step();
    n_checks++;
    if (sw_if.o_timer_reset_n !== 1'b0 || disp !== 24'h000000) begin
      n_fail++;
      $display("FAIL pause_clear: got rstn=%b digits=%h expected rstn=0 digits=000000",
               sw_if.o_timer_reset_n, disp);
    end
  endtask

  task automatic test_lap_with_tick();
    press_ss();
    step();
    ticks(5);
    sw_if.i_lap      = 1'b1;
    sw_if.i_basetick = 1'b1;
    step();
    sw_if.i_lap      = 1'b0;
    sw_if.i_basetick = 1'b0;
    step();
    n_checks++;
    if (sw_if.o_lap_active !== 1'b1 || disp !== 24'h000005) begin
      n_fail++;
      $display("FAIL lap_pre_increment: got lap=%b digits=%h expected lap=1 digits=000005",
               sw_if.o_lap_active, disp);
    end
    press_lap();
    step();
    n_checks++;
    if (disp !== 24'h000006) begin
      n_fail++;
      $display("FAIL lap_live_after_tick: got %h expected 000006", disp);
    end
    press_ss();
    step();
    press_clear();
    step();
  endtask

  task automatic test_overflow();
    press_ss();
    step();
    ticks(11999);
    n_checks++;
    if (disp !== 24'h015999 || sw_if.o_overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL at_max: got digits=%h ovf=%b expected digits=015999 ovf=0",
               disp, sw_if.o_overflow);
    end
    tick();
`ifdef STOPWATCH_WRAP_EN
    n_checks++;
    if (disp !== 24'h000000 || sw_if.o_overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap: got digits=%h ovf=%b expected digits=000000 ovf=1",
               disp, sw_if.o_overflow);
    end
    step();
    n_checks++;
    if (sw_if.o_overflow !== 1'b0 || sw_if.o_running !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_pulse_end: got ovf=%b run=%b expected ovf=0 run=1",
               sw_if.o_overflow, sw_if.o_running);
    end
`else
    n_checks++;
    if (disp !== 24'h015999 || sw_if.o_overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL saturate: got digits=%h ovf=%b expected digits=015999 ovf=1",
               disp, sw_if.o_overflow);
    end
    ticks(3);
    n_checks++;
    if (disp !== 24'h015999 || sw_if.o_overflow !== 1'b1 || sw_if.o_running !== 1'b1) begin
      n_fail++;
      $display("FAIL saturate_hold: got digits=%h ovf=%b run=%b expected digits=015999 ovf=1 run=1",
               disp, sw_if.o_overflow, sw_if.o_running);
    end
`endif
    press_ss();
    step();
    press_clear();
    step();
    n_checks++;
    if (sw_if.o_overflow !== 1'b0 || disp !== 24'h000000) begin
      n_fail++;
      $display("FAIL overflow_clear: got ovf=%b digits=%h expected ovf=0 digits=000000",
               sw_if.o_overflow, disp);
    end
  endtask

  task automatic test_reset_midrun();
    press_ss();
    step();
    ticks(3);
    i_reset            = 1'b1;
    sw_if.i_start_stop = 1'b1;
    step();
    i_reset            = 1'b0;
    sw_if.i_start_stop = 1'b0;
    n_checks++;
    if ({sw_if.o_timerenb, sw_if.o_timer_reset_n, sw_if.o_running} !== 3'b000 ||
        disp !== 24'h000000) begin
      n_fail++;
      $display("FAIL midrun_reset: got flags=%b digits=%h expected flags=000 digits=000000",
               {sw_if.o_timerenb, sw_if.o_timer_reset_n, sw_if.o_running}, disp);
    end
    step();
    n_checks++;
    if (sw_if.o_timer_reset_n !== 1'b0) begin
      n_fail++;
      $display("FAIL midrun_reset_idle: got rstn=%b expected 0", sw_if.o_timer_reset_n);
    end
  endtask

  initial begin
    sw_if.i_start_stop = 1'b0;
    sw_if.i_lap        = 1'b0;
    sw_if.i_clear      = 1'b0;
    sw_if.i_basetick   = 1'b0;
    test_reset();
    test_start_count();
    test_carry();
    test_pause_clear();
    test_lap();
    test_pause_with_tick();
    test_lap_with_tick();
    test_overflow();
    test_reset_midrun();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
